cfi_shadow_stack_stage: RTL and testbench

//  Commit-side control-flow integrity checker; replaces the stubbed CFI stage beside the commit stage.

---
 rtl/cfi_shadow_stack_stage.sv | 177 +++++++++++++++++
 tb/tb_cfi_shadow_stack_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_shadow_stack_stage.sv
// Commit-side CFI checker: hardware shadow stack for returns and landing-pad
// enforcement after indirect jumps, reporting violations as a registered exception.
package cfi_shadow_stack_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
endpackage

module cfi_shadow_stack_stage
  import cfi_shadow_stack_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned SS_DEPTH        = 16,
  parameter int unsigned VLEN            = 64,
  parameter int unsigned SW_CHECK_CAUSE  = 18
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_ack_i,
  input  logic [NR_COMMIT_PORTS*3-1:0] commit_op_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0] commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0]   commit_is_compr_i,
  input  logic [NR_COMMIT_PORTS*VLEN-1:0] commit_target_i,
  output logic                         cfi_wait_o,
  output exception_t                   cfi_fault_o,
  output logic [$clog2(SS_DEPTH):0]    ss_count_o
);
  localparam int unsigned PW = $clog2(SS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_CALL  = 3'd1;
  localparam logic [2:0] OP_RET   = 3'd2;
  localparam logic [2:0] OP_IJMP  = 3'd3;
  localparam logic [2:0] OP_LPAD  = 3'd4;
  localparam logic [2:0] OP_ICALL = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPECT_LPAD, ST_FAULT} state_e;

  state_e          state_q;
  logic [VLEN-1:0] stack_q [SS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   count_q;

  // Encodings 6 and 7 are reserved and behave as NONE.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op > 3'd5) ? OP_NONE : op;
  endfunction

  logic port0_cfi_c, upper_cfi_c;
  always_comb begin
    port0_cfi_c = commit_valid_i[0] && (norm_op(commit_op_i[2:0]) != OP_NONE);
    upper_cfi_c = 1'b0;
    for (int unsigned i = 1; i < NR_COMMIT_PORTS; i++) begin
      if (commit_valid_i[i] && (norm_op(commit_op_i[i*3 +: 3]) != OP_NONE)) upper_cfi_c = 1'b1;
    end
  end

  assign cfi_wait_o = en_i && port0_cfi_c && upper_cfi_c;

  // Pick the first retiring instruction (landing-pad check) and the first retiring CFI op.
  logic            first_seen_c, ev_found_c, ev_compr_c;
  logic [2:0]      first_op_c, ev_op_c;
  logic [VLEN-1:0] ev_pc_c, ev_target_c;
  always_comb begin
    first_seen_c = 1'b0;
    first_op_c   = OP_NONE;
    ev_found_c   = 1'b0;
    ev_op_c      = OP_NONE;
    ev_pc_c      = '0;
    ev_target_c  = '0;
    ev_compr_c   = 1'b0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (commit_valid_i[i] && commit_ack_i[i]) begin
        if (!first_seen_c) begin
          first_seen_c = 1'b1;
          first_op_c   = norm_op(commit_op_i[i*3 +: 3]);
        end
        if (!ev_found_c && (norm_op(commit_op_i[i*3 +: 3]) != OP_NONE)) begin
          ev_found_c  = 1'b1;
          ev_op_c     = norm_op(commit_op_i[i*3 +: 3]);
          ev_pc_c     = commit_pc_i[i*VLEN +: VLEN];
          ev_target_c = commit_target_i[i*VLEN +: VLEN];
          ev_compr_c  = commit_is_compr_i[i];
        end
      end
    end
  end

  logic            active_c, lpad_chk_c, push_c, pop_c, fault_c, set_expect_c;
  logic [63:0]     tval_c;
  logic [VLEN-1:0] ret_addr_c, top_c;
  always_comb begin
    active_c     = en_i && !flush_i && (state_q != ST_FAULT);
    lpad_chk_c   = active_c && (state_q == ST_EXPECT_LPAD) && first_seen_c;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    fault_c      = 1'b0;
    set_expect_c = 1'b0;
    tval_c       = '0;
    ret_addr_c   = ev_pc_c + (ev_compr_c ? VLEN'(2) : VLEN'(4));
    top_c        = stack_q[ptr_q - PW'(1)];
    if (lpad_chk_c && (first_op_c != OP_LPAD)) begin
      fault_c = 1'b1;
      tval_c  = 64'd2;
    end else if (active_c && ev_found_c) begin
      case (ev_op_c)
        OP_CALL, OP_ICALL: begin
          if (count_q == CW'(SS_DEPTH)) begin
            fault_c = 1'b1;
            tval_c  = 64'd3;
          end else begin
            push_c       = 1'b1;
            set_expect_c = (ev_op_c == OP_ICALL);
          end
        end
        OP_IJMP: set_expect_c = 1'b1;
        OP_RET: begin
          if (count_q == '0) begin
            fault_c = 1'b1;
            tval_c  = 64'd3;
          end else begin
            pop_c = 1'b1;
            if (top_c != ev_target_c) begin
              fault_c = 1'b1;
              tval_c  = 64'd3;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control state, stack pointer and registered fault; flush wins over any event.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      cfi_fault_o <= '0;
    end else if (flush_i) begin
      state_q     <= ST_IDLE;
      cfi_fault_o <= '0;
    end else begin
      if (fault_c) begin
        state_q           <= ST_FAULT;
        cfi_fault_o.cause <= 64'(SW_CHECK_CAUSE);
        cfi_fault_o.tval  <= tval_c;
        cfi_fault_o.valid <= 1'b1;
      end else if (set_expect_c) begin
        state_q <= ST_EXPECT_LPAD;
      end else if (lpad_chk_c) begin
        state_q <= ST_IDLE;
      end
      if (push_c) begin
        ptr_q   <= ptr_q + PW'(1);
        count_q <= count_q + CW'(1);
      end else if (pop_c) begin
        ptr_q   <= ptr_q - PW'(1);
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) stack_q[ptr_q] <= ret_addr_c;
  end

  assign ss_count_o = count_q;

endmodule

// File: tb/tb_cfi_shadow_stack_stage.sv
// Bench for cfi_shadow_stack_stage: directed scenarios plus random commit traffic
// compared each cycle against a queue-based shadow-stack model.
module tb_cfi_shadow_stack_stage;
  import cfi_shadow_stack_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned VLEN  = 64;
  localparam int unsigned CAUSE = 18;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] CALL  = 3'd1;
  localparam logic [2:0] RET   = 3'd2;
  localparam logic [2:0] IJMP  = 3'd3;
  localparam logic [2:0] LPAD  = 3'd4;
  localparam logic [2:0] ICALL = 3'd5;

  logic clk = 1'b0;
  logic rst_n, en, flush;
  logic [N-1:0]    valid, ack, compr;
  logic [2:0]      op  [N];
  logic [VLEN-1:0] pc  [N];
  logic [VLEN-1:0] tgt [N];
  logic            cfi_wait;
  exception_t      fault;
  logic [$clog2(DEPTH):0] ss_count;

  always #5 clk = ~clk;

  cfi_shadow_stack_stage #(
    .NR_COMMIT_PORTS(N), .SS_DEPTH(DEPTH), .VLEN(VLEN), .SW_CHECK_CAUSE(CAUSE)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .en_i              (en),
    .flush_i           (flush),
    .commit_valid_i    (valid),
    .commit_ack_i      (ack),
    .commit_op_i       ({op[1], op[0]}),
    .commit_pc_i       ({pc[1], pc[0]}),
    .commit_is_compr_i (compr),
    .commit_target_i   ({tgt[1], tgt[0]}),
    .cfi_wait_o        (cfi_wait),
    .cfi_fault_o       (fault),
    .ss_count_o        (ss_count)
  );

  // Reference model state: return addresses as a queue, plus pending-landing-pad and fault flags.
  logic [63:0] m_stack [$];
  bit          m_expect;
  bit          m_fault;
  logic [63:0] m_tval;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit is_cfi(input logic [2:0] o);
    return (o >= 3'd1) && (o <= 3'd5);
  endfunction

  task automatic raise(input logic [63:0] t);
    m_fault = 1'b1;
    m_tval  = t;
  endtask

  // Apply one clock edge worth of architectural effects to the model.
  task automatic model_step();
    bit          first;
    logic [2:0]  o;
    logic [63:0] top;
    if (!rst_n) begin
      m_stack.delete();
      m_expect = 1'b0;
      m_fault  = 1'b0;
      m_tval   = '0;
      return;
    end
    if (flush) begin
      m_expect = 1'b0;
      m_fault  = 1'b0;
      m_tval   = '0;
      return;
    end
    if (!en || m_fault) return;
    first = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!(valid[i] && ack[i])) continue;
      o = is_cfi(op[i]) ? op[i] : NONE;
      if (first && m_expect) begin
        m_expect = 1'b0;
        if (o != LPAD) begin raise(64'd2); return; end
      end
      first = 1'b0;
      case (o)
        CALL, ICALL: begin
          if (m_stack.size() == DEPTH) begin raise(64'd3); return; end
          m_stack.push_back(pc[i] + (compr[i] ? 64'd2 : 64'd4));
          if (o == ICALL) m_expect = 1'b1;
        end
        IJMP: m_expect = 1'b1;
        RET: begin
          if (m_stack.size() == 0) begin raise(64'd3); return; end
          top = m_stack.pop_back();
          if (top != tgt[i]) begin raise(64'd3); return; end
        end
        default: ;
      endcase
    end
  endtask

  // Inputs are set at a negedge; check wait, advance the model, then check state at the next negedge.
  task automatic step();
    logic exp_wait;
    #1;
    exp_wait = en && valid[0] && is_cfi(op[0]) && valid[1] && is_cfi(op[1]);
    check("cfi_wait", 64'(cfi_wait), 64'(exp_wait));
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("fault_valid", 64'(fault.valid), 64'(m_fault));
    check("fault_tval", fault.tval, m_fault ? m_tval : 64'd0);
    check("fault_cause", fault.cause, m_fault ? 64'(CAUSE) : 64'd0);
    check("ss_count", 64'(ss_count), 64'(m_stack.size()));
  endtask

  task automatic idle();
    valid = '0;
    ack   = '0;
    compr = '0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      op[i]  = NONE;
      pc[i]  = '0;
      tgt[i] = '0;
    end
  endtask

  task automatic put(input int p, input logic [2:0] o, input logic [63:0] a,
                     input logic c, input logic [63:0] t);
    valid[p] = 1'b1;
    ack[p]   = 1'b1;
    op[p]    = o;
    pc[p]    = a;
    compr[p] = c;
    tgt[p]   = t;
  endtask

  initial begin
    logic w;
    int   r;
    rst_n = 1'b0;
    en    = 1'b1;
    idle();
    step();
    step();
    check("d_reset_count", 64'(ss_count), 64'd0);
    check("d_reset_wait", 64'(cfi_wait), 64'd0);
    rst_n = 1'b1;

    // Matching call/return pair.
    idle(); put(0, CALL, 64'h1000, 1'b0, 64'h0); step();
    check("d_call_count", 64'(ss_count), 64'd1);
    idle(); put(0, RET, 64'h1100, 1'b0, 64'h1004); step();
    check("d_ret_count", 64'(ss_count), 64'd0);
    check("d_ret_nofault", 64'(fault.valid), 64'd0);

    // Compressed call returns to pc+2, so target pc+4 is a mismatch.
    idle(); put(0, CALL, 64'h2000, 1'b1, 64'h0); step();
    idle(); put(0, RET, 64'h2100, 1'b0, 64'h2004); step();
    check("d_mismatch_valid", 64'(fault.valid), 64'd1);
    check("d_mismatch_cause", fault.cause, 64'd18);
    check("d_mismatch_tval", fault.tval, 64'd3);
    idle(); flush = 1'b1; step();
    check("d_flush_clear", 64'(fault.valid), 64'd0);
    check("d_flush_count", 64'(ss_count), 64'd0);

    // Landing-pad enforcement.
    idle(); put(0, IJMP, 64'h3000, 1'b0, 64'h4000); step();
    idle(); put(0, NONE, 64'h4000, 1'b0, 64'h0); step();
    check("d_nolpad_tval", fault.tval, 64'd2);
    check("d_nolpad_valid", 64'(fault.valid), 64'd1);
    idle(); flush = 1'b1; step();
    idle(); put(0, IJMP, 64'h3000, 1'b0, 64'h4000); step();
    idle(); put(0, LPAD, 64'h4000, 1'b0, 64'h0); step();
    check("d_lpad_ok", 64'(fault.valid), 64'd0);

    // Overflow on the (DEPTH+1)th call.
    for (int k = 0; k <= DEPTH; k++) begin
      idle(); put(0, CALL, 64'h5000 + 64'(k * 8), 1'b0, 64'h0); step();
    end
    check("d_full_count", 64'(ss_count), 64'(DEPTH));
    check("d_full_tval", fault.tval, 64'd3);
    idle(); flush = 1'b1; step();
    check("d_full_flush_count", 64'(ss_count), 64'(DEPTH));

    // Reset drops the stack; a return on the empty stack faults.
    idle(); rst_n = 1'b0; step();
    check("d_rst_count", 64'(ss_count), 64'd0);
    rst_n = 1'b1;
    idle(); put(0, RET, 64'h6000, 1'b0, 64'h0); step();
    check("d_empty_tval", fault.tval, 64'd3);
    check("d_empty_count", 64'(ss_count), 64'd0);
    idle(); flush = 1'b1; step();

    // Two CFI ops on both ports: commit waits and only port 0 retires.
    idle();
    put(0, CALL, 64'h7000, 1'b0, 64'h0);
    put(1, RET, 64'h7004, 1'b0, 64'h7004);
    ack[1] = 1'b0;
    #1;
    check("d_wait_high", 64'(cfi_wait), 64'd1);
    step();
    check("d_wait_count", 64'(ss_count), 64'd1);
    idle(); put(0, RET, 64'h7004, 1'b0, 64'h7004); step();
    check("d_wait_ret_count", 64'(ss_count), 64'd0);
    check("d_wait_ret_fault", 64'(fault.valid), 64'd0);

    // Random commit traffic; the commit stage honours cfi_wait and retires in order.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      en    = ($urandom_range(15) != 0);
      rst_n = ($urandom_range(499) != 0);
      flush = m_fault ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
      for (int p = 0; p < N; p++) begin
        valid[p] = ($urandom_range(3) != 0);
        r        = $urandom_range(9);
        op[p]    = (r >= 8) ? RET : 3'(r);
        pc[p]    = {$urandom, $urandom};
        compr[p] = 1'($urandom_range(1));
        tgt[p]   = (m_stack.size() > 0 && $urandom_range(3) != 0) ? m_stack[$] : {$urandom, $urandom};
      end
      w      = en && valid[0] && is_cfi(op[0]) && valid[1] && is_cfi(op[1]);
      ack[0] = valid[0] && ($urandom_range(3) != 0);
      ack[1] = ack[0] && valid[1] && !w && ($urandom_range(1) == 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
